ddr2_cmd_arbiter: RTL
=====================

# ddr2_cmd_arbiter

Shares the single command/data port of the DDR2 controller among NUM_REQ independent traffic sources (test drivers, DMA-style masters). Arbitrates round-robin per command, forwards the winner's command only when the controller's CMD and DATA FIFOs can take it, and locks the grant for the data beats of a block write. Sits between the requesters and the controller's cmd/sz/op/addr/din inputs and fillcount/notfull outputs.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- IDW, 3: width of grant_id; must satisfy 2**IDW >= NUM_REQ.
- clk  in  1  controller clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- req_valid  in  NUM_REQ  requester i has a command or data beat pending.
- req_cmd  in  3*NUM_REQ  packed, slice i = [3i+2:3i]; 0/7 NOP, 1 SCR, 2 SCW, 3 BLR, 4 BLW, 5 ATR, 6 ATW.
- req_sz  in  2*NUM_REQ  block size code.
- req_op  in  3*NUM_REQ  atomic opcode.
- req_addr  in  25*NUM_REQ  address.
- req_din  in  16*NUM_REQ  write data.
- req_ready  out  NUM_REQ  beat from requester i is consumed this edge.
- fillcount  in  7  controller data FIFO fill level.
- notfull  in  1  controller command FIFO has space.
- cmd  out  3  command to controller; 0 when idle or on data-only beats.
- sz, op  out  2, 3  forwarded size and opcode.
- addr  out  25  forwarded address.
- din  out  16  forwarded write data.
- busy  out  1  a grant is held.
- grant_id  out  IDW  index of the current owner; 0 when not busy.

## Operation
- Space terms: dspace = (fillcount <= 63); cspace = notfull.
- States: IDLE, GRANT, BURST.
- IDLE: busy = 0, all outputs 0, req_ready = 0. If any req_valid is high, the winner is registered as owner and the FSM enters GRANT. The winner is the first valid index starting at rr_ptr and wrapping modulo NUM_REQ.
- GRANT: cmd/sz/op/addr/din combinationally mirror the owner's slices.
- Accept rules in GRANT:
  - NOP (0/7): always accepted. cmd is forced to 0 and nothing reaches the controller.
  - SCR/BLR (1/3): accepted when cspace.
  - SCW/ATR/ATW (2/5/6): accepted when cspace && dspace.
  - BLW (4): accepted when cspace && dspace.
- On acceptance req_ready[owner] = 1 for that cycle.
- On a non-BLW accept: rr_ptr <= (owner+1) mod NUM_REQ, then IDLE.
- On a BLW accept: beat_cnt <= 8*(sz+1)-1 (6 bits, max 31), then BURST. The first data word rides with the command beat.
- If req_valid[owner] drops in GRANT before acceptance, the FSM returns to IDLE with no transfer and rr_ptr is unchanged.
- BURST:
  - cmd = 0, addr/sz/op = 0, din mirrors owner data.
  - A beat is consumed when req_valid[owner] && dspace. req_ready pulses, beat_cnt decrements, and the controller samples din.
  - When a beat is consumed with beat_cnt == 1, rr_ptr advances and the FSM returns to IDLE.
  - Owner stall (req_valid low) or a full data FIFO holds the state. There is no timeout; the grant is never preempted mid-burst.
- Requesters must hold every field stable from req_valid high until req_ready.

## Timing
- Reset: state IDLE, rr_ptr 0, beat_cnt 0, owner 0. cmd/sz/op/addr/din/busy/grant_id/req_ready all 0.
- Arbitration latency: 1 cycle. A req_valid sampled at edge N puts the command on cmd during cycle N+1. It is accepted at edge N+2 if space allows.
- Throughput: at most one command per 2 cycles (IDLE cycle between grants). BLW data runs 1 beat per cycle while space allows.
- Inputs fillcount and notfull are used combinationally; req_ready depends combinationally on them.
- Boundaries:
  - fillcount = 63 counts as space; 64 does not.
  - rr_ptr wraps from NUM_REQ-1 to 0.
  - Simultaneous requests resolve per rr_ptr only.
  - A reset assertion mid-BURST aborts the burst; no further beats are issued.

## Configuration
- DDR2_ARB_FIXED_PRIO_EN defined: the winner is the lowest valid index, and rr_ptr is held at 0 (all other behaviour is identical).
- Undefined: round-robin as described.

## Test plan
- Reset with all req_valid high, reset low for 3 cycles -> cmd = 0, busy = 0 throughout; first grant is to requester 0 one cycle after reset release.
- Requesters 0..3 each issue SCW addr 0x10+i, din 0xFACE, with fillcount 0 and notfull 1 -> controller sees cmd = 2 from order 0,1,2,3, one accept every 2 cycles.
- Requester 1 SCR with notfull = 0 for 5 cycles -> cmd = 1 is held, req_ready[1] stays 0; accept on the first cycle with notfull = 1.
- Requester 2 BLW with sz = 1 while requester 0 is valid -> 16 data beats to requester 2 with cmd = 4 then 0. fillcount = 64 for 3 cycles mid-burst stalls din; requester 0 is granted only after beat 16.
- Requester 3 NOP (cmd 7) -> req_ready[3] pulses, controller cmd stays 0, rr_ptr becomes 0.
- With DDR2_ARB_FIXED_PRIO_EN and requesters 0 and 3 continuously valid -> requester 3 is never granted.

Source files
------------

// File: rtl/ddr2_cmd_arbiter.sv
// ddr2_cmd_arbiter: shares the DDR2 controller command/data port among
// NUM_REQ requesters. Round-robin per command, forwards a command only when
// the controller CMD/DATA FIFOs can take it, and holds the grant for the data
// beats of a block write (BLW).
// Optional build macro: DDR2_ARB_FIXED_PRIO_EN selects lowest-index-wins
// arbitration with rr_ptr held at 0.
module ddr2_cmd_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IDW     = 3
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_REQ-1:0]     req_valid,
   input  logic [3*NUM_REQ-1:0]   req_cmd,
   input  logic [2*NUM_REQ-1:0]   req_sz,
   input  logic [3*NUM_REQ-1:0]   req_op,
   input  logic [25*NUM_REQ-1:0]  req_addr,
   input  logic [16*NUM_REQ-1:0]  req_din,
   output logic [NUM_REQ-1:0]     req_ready,
   input  logic [6:0]             fillcount,
   input  logic                   notfull,
   output logic [2:0]             cmd,
   output logic [1:0]             sz,
   output logic [2:0]             op,
   output logic [24:0]            addr,
   output logic [15:0]            din,
   output logic                   busy,
   output logic [IDW-1:0]         grant_id
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_BURST = 2'd2
   } state_t;

   localparam logic [2:0] CMD_NOP = 3'd0;
   localparam logic [2:0] CMD_SCR = 3'd1;
   localparam logic [2:0] CMD_SCW = 3'd2;
   localparam logic [2:0] CMD_BLR = 3'd3;
   localparam logic [2:0] CMD_BLW = 3'd4;
   localparam logic [2:0] CMD_ATR = 3'd5;
   localparam logic [2:0] CMD_ATW = 3'd6;
   localparam logic [2:0] CMD_NP7 = 3'd7;

`ifdef DDR2_ARB_FIXED_PRIO_EN
   localparam bit FIXED_PRIO = 1'b1;
`else
   localparam bit FIXED_PRIO = 1'b0;
`endif

   state_t           state, state_nx;
   logic [IDW-1:0]   owner, owner_nx;
   logic [IDW-1:0]   rr_ptr, rr_nx;
   logic [5:0]       beat_cnt, cnt_nx;

   // Owner's fields, selected by shifting so index widths never mismatch.
   logic             own_valid;
   logic [2:0]       own_cmd;
   logic [1:0]       own_sz;
   logic [2:0]       own_op;
   logic [24:0]      own_addr;
   logic [15:0]      own_din;
   logic [NUM_REQ-1:0] own_onehot;

   logic             dspace, cspace;
   logic             is_nop, needs_data, accept;
   logic [IDW-1:0]   next_rr;

   logic             win_found;
   logic [IDW-1:0]   win_id;

   assign dspace = (fillcount <= 7'd63);
   assign cspace = notfull;

   assign own_onehot = NUM_REQ'(1) << owner;
   assign own_valid  = |(req_valid & own_onehot);
   assign own_cmd    = 3'(req_cmd  >> (3  * owner));
   assign own_sz     = 2'(req_sz   >> (2  * owner));
   assign own_op     = 3'(req_op   >> (3  * owner));
   assign own_addr   = 25'(req_addr >> (25 * owner));
   assign own_din    = 16'(req_din  >> (16 * owner));

   assign is_nop     = (own_cmd == CMD_NOP) || (own_cmd == CMD_NP7);
   assign needs_data = (own_cmd == CMD_SCW) || (own_cmd == CMD_BLW) ||
                       (own_cmd == CMD_ATR) || (own_cmd == CMD_ATW);
   // SCR/BLR only need command FIFO space; writes and atomics need both.
   assign accept     = own_valid &&
                       (is_nop || (cspace && (!needs_data || dspace)));

   // Pointer advances past the owner on completion; fixed priority pins it to 0.
   assign next_rr = FIXED_PRIO ? '0 :
                    (owner == IDW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

   // Winner search: first valid index from the start point, wrapping.
   always_comb begin
      int            idx;
      logic [NUM_REQ-1:0] sh;
      win_found = 1'b0;
      win_id    = '0;
      idx       = 0;
      sh        = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = (FIXED_PRIO ? 0 : int'(rr_ptr)) + i;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         sh = req_valid >> idx;
         if (!win_found && sh[0]) begin
            win_found = 1'b1;
            win_id    = IDW'(idx);
         end
      end
   end

   // Next-state and output decode for the IDLE/GRANT/BURST FSM.
   always_comb begin
      // NOTE: every output and next-state term gets a default first, so no
      // path through the case statement can leave one unassigned (no latches).
      state_nx  = state;
      owner_nx  = owner;
      rr_nx     = rr_ptr;
      cnt_nx    = beat_cnt;
      cmd       = '0;
      sz        = '0;
      op        = '0;
      addr      = '0;
      din       = '0;
      busy      = 1'b0;
      grant_id  = '0;
      req_ready = '0;

      case (state)
         ST_IDLE: begin
            if (win_found) begin
               owner_nx = win_id;
               state_nx = ST_GRANT;
            end
         end

         ST_GRANT: begin
            busy     = 1'b1;
            grant_id = owner;
            cmd      = is_nop ? CMD_NOP : own_cmd;
            sz       = own_sz;
            op       = own_op;
            addr     = own_addr;
            din      = own_din;
            if (!own_valid) begin
               // Requester withdrew: drop the grant, pointer untouched.
               state_nx = ST_IDLE;
            end else if (accept) begin
               req_ready = own_onehot;
               if (own_cmd == CMD_BLW) begin
                  // Command beat carried the first word; 8*(sz+1)-1 remain.
                  cnt_nx   = {1'b0, own_sz, 3'b111};
                  state_nx = ST_BURST;
               end else begin
                  rr_nx    = next_rr;
                  state_nx = ST_IDLE;
               end
            end
         end

         ST_BURST: begin
            busy     = 1'b1;
            grant_id = owner;
            din      = own_din;
            if (own_valid && dspace) begin
               req_ready = own_onehot;
               cnt_nx    = beat_cnt - 6'd1;
               if (beat_cnt == 6'd1) begin
                  rr_nx    = next_rr;
                  state_nx = ST_IDLE;
               end
            end
         end

         default: state_nx = ST_IDLE;
      endcase
   end

   // State registers; reset aborts any grant or burst immediately.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= ST_IDLE;
         owner    <= '0;
         rr_ptr   <= '0;
         beat_cnt <= '0;
      end else begin
         // NOTE: non-blocking assignments so all registers update together
         // from the values computed in the same cycle.
         state    <= state_nx;
         owner    <= owner_nx;
         rr_ptr   <= rr_nx;
         beat_cnt <= cnt_nx;
      end
   end

endmodule
